// File: rtl/bit_pattern_scan_ctrl_if.sv
// Handshake and configuration bundle between a serial bit source / host and bit_pattern_scan_ctrl.
interface bit_pattern_scan_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 16,
  parameter int CNT_W = 8
);
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic [LEN_W-1:0] cfg_frame_len;
  logic             start;
  logic             in_valid;
  logic             in_bit;
  logic             in_ready;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             busy;
  logic             done;
  logic             cfg_err;

  modport master (
    output cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_frame_len,
    output start, in_valid, in_bit,
    input  in_ready, match, match_count, busy, done, cfg_err
  );

  modport slave (
    input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, cfg_frame_len,
    input  start, in_valid, in_bit,
    output in_ready, match, match_count, busy, done, cfg_err
  );
endinterface

// File: rtl/bit_pattern_scan_ctrl.sv
// Programmable serial bit-pattern scanner: runs one frame, pulses per match, counts matches.
// state  | meaning
// S_IDLE | waiting for cfg_load / start; match_count holds last result
// S_SCAN | accepting frame bits, detecting matches
// S_DONE | single-cycle end-of-frame, final count visible
module bit_pattern_scan_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  bit_pattern_scan_ctrl_if.slave bus
);

  localparam int HC_W = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [3:0]       len_q, len_d;
  logic             ovl_q, ovl_d;
  logic [LEN_W-1:0] flen_q, flen_d;
  logic             cfg_vld_q, cfg_vld_d;
  logic             cfg_err_q, cfg_err_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [HC_W-1:0]  hist_cnt_q, hist_cnt_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic             accept;
  logic             last_bit;
  logic             cfg_legal;
  logic             go_scan;
  logic             hit;
  logic [PAT_W-1:0] hist_shift;
  logic [PAT_W-1:0] len_mask;
  logic [HC_W-1:0]  hist_cnt_inc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    accept       = (state_q == S_SCAN) && bus.in_valid;
    last_bit     = (bit_cnt_q + LEN_W'(1)) == flen_q;
    cfg_legal    = (bus.cfg_len != 4'd0) && (int'(bus.cfg_len) <= PAT_W) &&
                   (bus.cfg_frame_len != '0);
    go_scan      = (state_q == S_IDLE) && bus.start && cfg_vld_q && !cfg_err_q;
    hist_shift   = (hist_q << 1) | PAT_W'(bus.in_bit);
    hist_cnt_inc = (int'(hist_cnt_q) >= PAT_W) ? hist_cnt_q : hist_cnt_q + HC_W'(1);
    for (int i = 0; i < PAT_W; i++) len_mask[i] = (i < int'(len_q));
    // Match uses the history as it will be after shifting in the current bit.
    hit          = (int'(hist_cnt_inc) >= int'(len_q)) &&
                   (((hist_shift ^ pat_q) & len_mask) == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (go_scan) state_d = S_SCAN;
      S_SCAN: if (accept && last_bit) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pat_d       = pat_q;
    len_d       = len_q;
    ovl_d       = ovl_q;
    flen_d      = flen_q;
    cfg_vld_d   = cfg_vld_q;
    cfg_err_d   = cfg_err_q;
    hist_d      = hist_q;
    hist_cnt_d  = hist_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    match_d     = 1'b0;
    match_cnt_d = match_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_load) begin
          if (cfg_legal) begin
            pat_d     = bus.cfg_pattern;
            len_d     = bus.cfg_len;
            ovl_d     = bus.cfg_overlap;
            flen_d    = bus.cfg_frame_len;
            cfg_vld_d = 1'b1;
            cfg_err_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
        if (bus.start) begin
          if (go_scan) begin
            match_cnt_d = '0;
            hist_d      = '0;
            hist_cnt_d  = '0;
            bit_cnt_d   = '0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_SCAN: begin
        if (accept) begin
          hist_d     = hist_shift;
          hist_cnt_d = hist_cnt_inc;
          bit_cnt_d  = bit_cnt_q + LEN_W'(1);
          if (hit) begin
            match_d = 1'b1;
            if (match_cnt_q != '1) match_cnt_d = match_cnt_q + CNT_W'(1);
            // Non-overlapping mode forgets the bits that formed this match.
            if (!ovl_q) hist_cnt_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat_q       <= '0;
      len_q       <= '0;
      ovl_q       <= 1'b0;
      flen_q      <= '0;
      cfg_vld_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      hist_q      <= '0;
      hist_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      match_q     <= 1'b0;
      match_cnt_q <= '0;
    end else begin
      pat_q       <= pat_d;
      len_q       <= len_d;
      ovl_q       <= ovl_d;
      flen_q      <= flen_d;
      cfg_vld_q   <= cfg_vld_d;
      cfg_err_q   <= cfg_err_d;
      hist_q      <= hist_d;
      hist_cnt_q  <= hist_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      match_q     <= match_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  always_comb begin
    bus.in_ready    = (state_q == S_SCAN);
    bus.busy        = (state_q != S_IDLE);
    bus.done        = (state_q == S_DONE);
    bus.match       = match_q;
    bus.match_count = match_cnt_q;
    bus.cfg_err     = cfg_err_q;
  end

endmodule

// File: doc/bit_pattern_scan_ctrl.md
Name: bit_pattern_scan_ctrl

Overview:
- Frame-level controller for serial bit-pattern detection.
- Holds a programmable pattern (1..PAT_W bits, overlapping or non-overlapping mode).
- Sequences one frame of serial bits through a valid/ready handshake, pulses on each match and counts matches.
- Signals frame completion with the final count. Sits between the serial bit source and the status/interrupt logic; replaces the fixed-pattern detectors.

Parameters:
- PAT_W, 8, maximum pattern length in bits
- LEN_W, 16, width of frame-length field
- CNT_W, 8, width of match counter (saturating)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- cfg_load  input  1  load configuration (honoured only in IDLE)
- cfg_pattern  input  PAT_W  pattern; bit [cfg_len-1] is the first bit received
- cfg_len  input  4  pattern length, legal 1..PAT_W
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- cfg_frame_len  input  LEN_W  number of bits in the frame, legal >= 1
- start  input  1  begin scanning a frame (honoured only in IDLE)
- in_valid  input  1  serial bit valid
- in_bit  input  1  serial data bit
- in_ready  output  1  controller accepts a bit
- match  output  1  one-cycle pulse per detected match
- match_count  output  CNT_W  matches in current/last frame
- busy  output  1  high in SCAN and DONE
- done  output  1  one-cycle pulse at end of frame
- cfg_err  output  1  sticky illegal-configuration flag

Behaviour:
- Reset (async): state IDLE; pattern, len, overlap and frame_len registers cleared; history and hist_cnt cleared; in_ready, match, done, busy, cfg_err = 0; match_count = 0.
- Configuration:
  - cfg_load in IDLE with cfg_len in 1..PAT_W and cfg_frame_len != 0: latch all cfg_* fields and clear cfg_err.
  - cfg_load in IDLE with an illegal field: config unchanged, cfg_err <= 1.
  - cfg_load outside IDLE: ignored.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN on start when cfg_err = 0 and a valid config has been loaded since reset. On entry: match_count <= 0, history <= 0, hist_cnt <= 0, bit counter <= 0. start with no valid config: stay IDLE, cfg_err <= 1.
- SCAN:
  - in_ready = 1. A bit is accepted on an edge where in_valid & in_ready.
  - On acceptance:
    - history <= {history[PAT_W-2:0], in_bit}.
    - hist_cnt increments, saturating at PAT_W.
    - Bit counter increments.
  - Match condition, using post-shift history: hist_cnt >= len and the low len bits of history equal the low len bits of pattern.
  - On a match:
    - match <= 1 (registered; visible the cycle after the accepting edge).
    - match_count increments, saturating at 2^CNT_W-1.
    - If cfg_overlap = 0, hist_cnt <= 0 so matched bits are not reused.
  - No acceptance: history and counters hold; match <= 0.
  - Accepting bit number frame_len: go to DONE on the same edge.
- DONE: exactly one cycle. done = 1, busy = 1, in_ready = 0. A match on the last bit pulses in this same cycle, and match_count is already final. Then return to IDLE.
- match_count holds its value in IDLE until the next start.
- start or cfg_load during SCAN/DONE: ignored.
- busy = (state != IDLE).
- All outputs are registered or decoded from the state register; there is no combinational path from inputs to outputs.

Test Plan:
- Non-overlapping 1010: pattern 1010, len 4, overlap 0, frame 10, stream 1010101010 -> match pulses after bits 4 and 8; done with match_count = 2.
- Overlapping 1010: same stream with overlap 1 -> matches after bits 4, 6, 8, 10; bit 10's match pulses together with done; match_count = 4.
- Handshake gaps and illegal start: same as the non-overlapping case but in_valid deasserted for 3 random cycles between bits -> identical match positions in bit count, count = 2, history unchanged during gaps; also start without prior load -> stays IDLE, cfg_err = 1.
- Illegal configuration: cfg_len = 0, then cfg_len = 9, then cfg_frame_len = 0 -> cfg_err = 1 each time and prior config retained; a subsequent legal load clears cfg_err.
- Saturation: pattern 1, len 1, overlap 1, frame 300, all ones -> match pulses every accepted bit; match_count stops at 255; done after bit 300.
- Reset mid-frame: assert reset after 5 bits of the first case -> immediately busy = 0, in_ready = 0, match_count = 0, cfg_err = 0, config cleared; start then stays IDLE with cfg_err = 1 until reloaded.
